piezo_tune_sched: RTL and testbench



---
 rtl/piezo_pkg.sv | 55 +++++
 rtl/piezo_tone_gen.sv | 46 ++++
 rtl/piezo_tune_sched.sv | 139 +++++++++++++
 tb/tb_piezo_tune_sched.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piezo_pkg.sv
// Shared types and the constant note table for the piezo tune scheduler.
package piezo_pkg;

  // Tone half-periods in clocks.
  localparam logic [15:0] HpD7 = 16'd21285;
  localparam logic [15:0] HpE7 = 16'd18960;
  localparam logic [15:0] HpF7 = 16'd17882;
  localparam logic [15:0] HpA6 = 16'd28409;

  localparam int unsigned LenFanfare = 8;
  localparam int unsigned LenError   = 2;
  localparam int unsigned LenChirp   = 1;

  typedef enum logic [1:0] {DurFull, DurLong, DurShort} dur_code_e;

  typedef struct packed {
    logic [15:0] half_period;
    dur_code_e   code;
  } note_t;

  typedef enum logic [1:0] {StIdle, StPlay, StDone} state_e;

  // Note idx of tune (0 fanfare, 1 error, 2 chirp).
  function automatic note_t note_lookup(input logic [1:0] tune, input logic [2:0] idx);
    note_t n;
    n = '{half_period: HpF7, code: DurShort};
    case (tune)
      2'd0: begin
        case (idx)
          3'd0:    n = '{half_period: HpD7, code: DurFull};
          3'd1:    n = '{half_period: HpE7, code: DurFull};
          3'd2:    n = '{half_period: HpF7, code: DurFull};
          3'd3:    n = '{half_period: HpE7, code: DurLong};
          3'd4:    n = '{half_period: HpF7, code: DurShort};
          3'd5:    n = '{half_period: HpD7, code: DurLong};
          3'd6:    n = '{half_period: HpA6, code: DurShort};
          default: n = '{half_period: HpD7, code: DurFull};
        endcase
      end
      2'd1:    n = '{half_period: HpA6, code: DurLong};
      default: n = '{half_period: HpF7, code: DurShort};
    endcase
    return n;
  endfunction

  // Index of the final note of a tune.
  function automatic logic [2:0] tune_last(input logic [1:0] tune);
    case (tune)
      2'd0:    return 3'(LenFanfare - 1);
      2'd1:    return 3'(LenError - 1);
      default: return 3'(LenChirp - 1);
    endcase
  endfunction

endpackage

// File: rtl/piezo_tone_gen.sv
// Square-wave generator: toggles piezo every (half_period + 1) enabled clocks.
module piezo_tone_gen
  import piezo_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic        clr_i,
  input  logic [15:0] half_period_i,
  output logic        piezo_o
);

  logic [15:0] cnt_q, cnt_d;
  logic        piezo_q, piezo_d;

  // Counter/toggle next state; clr restarts the period but keeps the level.
  always_comb begin
    cnt_d   = cnt_q;
    piezo_d = piezo_q;
    if (!en_i) begin
      cnt_d   = '0;
      piezo_d = 1'b0;
    end else if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q == half_period_i) begin
      cnt_d   = '0;
      piezo_d = ~piezo_q;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Tone state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      piezo_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      piezo_q <= piezo_d;
    end
  end

  assign piezo_o = piezo_q;

endmodule

// File: rtl/piezo_tune_sched.sv
// Fixed-priority scheduler for the shared piezo sounder.
// Optional macro PIEZO_PREEMPT_EN: a higher-priority pending request abandons the
// current tune at its next note expiry.
module piezo_tune_sched
  import piezo_pkg::*;
#(
  parameter int unsigned FAST_SIM = 1,
  parameter int unsigned DUR_W    = 23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req_i,
  output logic [2:0] grant_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       piezo_o,
  output logic       piezo_n_o
);

  localparam logic [DUR_W:0] DurInc = (FAST_SIM != 0) ? (DUR_W+1)'(16) : (DUR_W+1)'(1);

  state_e       state_q, state_d;
  logic [2:0]   pending_q, pending_d;
  logic [2:0]   grant_q, grant_d;
  logic [1:0]   tune_q, tune_d;
  logic [2:0]   note_q, note_d;
  logic [DUR_W:0] dur_q, dur_d;

  note_t        note_cur;
  logic [DUR_W:0] dur_sum;
  logic         expired;
  logic         sel_valid;
  logic [1:0]   sel_idx;
  logic [2:0]   clr_pend;
  logic         tone_clr;
  logic         tone_en;

  // Current note, duration expiry and lowest-index pending requester.
  always_comb begin
    note_cur = note_lookup(tune_q, note_q);
    dur_sum  = dur_q + DurInc;
    case (note_cur.code)
      DurFull:  expired = dur_sum[DUR_W];
      DurLong:  expired = dur_sum[DUR_W] & dur_sum[DUR_W-1];
      DurShort: expired = dur_sum[DUR_W-1];
      default:  expired = 1'b0;
    endcase
    sel_valid = |pending_q;
    if (pending_q[0])      sel_idx = 2'd0;
    else if (pending_q[1]) sel_idx = 2'd1;
    else                   sel_idx = 2'd2;
  end

  // Scheduler FSM next state.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    tune_d   = tune_q;
    note_d   = note_q;
    dur_d    = '0;
    clr_pend = '0;
    tone_clr = 1'b0;
    case (state_q)
      StIdle: begin
        if (sel_valid) begin
          state_d  = StPlay;
          grant_d  = 3'(1) << sel_idx;
          tune_d   = sel_idx;
          note_d   = '0;
          clr_pend = 3'(1) << sel_idx;
        end
      end
      StPlay: begin
        dur_d = dur_sum;
        if (expired) begin
          dur_d    = '0;
`ifdef PIEZO_PREEMPT_EN
          // Any pending bit below the current index outranks the running tune.
          if ((pending_q & ((3'(1) << tune_q) - 3'd1)) != 3'd0) begin
            grant_d  = 3'(1) << sel_idx;
            tune_d   = sel_idx;
            note_d   = '0;
            clr_pend = 3'(1) << sel_idx;
            tone_clr = 1'b1;
          end else
`endif
          if (note_q == tune_last(tune_q)) begin
            state_d = StDone;
            grant_d = '0;
          end else begin
            note_d   = note_q + 3'd1;
            tone_clr = 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // A request on the grant edge re-arms the same requester.
    pending_d = (pending_q & ~clr_pend) | req_i;
  end

  // Scheduler state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pending_q <= '0;
      grant_q   <= '0;
      tune_q    <= '0;
      note_q    <= '0;
      dur_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      tune_q    <= tune_d;
      note_q    <= note_d;
      dur_q     <= dur_d;
    end
  end

  // Tone runs only while staying in PLAY, so it is zeroed on entry and exit.
  assign tone_en = (state_q == StPlay) && (state_d == StPlay);

  piezo_tone_gen u_tone (
    .clk           (clk),
    .rst_n         (rst_n),
    .en_i          (tone_en),
    .clr_i         (tone_clr),
    .half_period_i (note_cur.half_period),
    .piezo_o       (piezo_o)
  );

  assign grant_o   = grant_q;
  assign busy_o    = |grant_q;
  assign done_o    = (state_q == StDone);
  assign piezo_n_o = ~piezo_o;

endmodule

// File: tb/tb_piezo_tune_sched.sv
// Scoreboard bench for piezo_tune_sched: a tune-level reference model predicts
// grant/done events; a monitor compares them as the DUT presents them.
module tb_piezo_tune_sched;

  localparam int DurW = 8;
  localparam int HpD7 = 21285;
  localparam int HpE7 = 18960;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req;
  logic [2:0] grant;
  logic       busy, done, piezo, piezo_n;

  logic       rst_f_n;
  logic [2:0] req_f;
  logic [2:0] grant_f;
  logic       busy_f, done_f, piezo_f, piezo_n_f;

  int checks   = 0;
  int failures = 0;
  bit fast_finished = 1'b0;

  always #5 clk = ~clk;

  piezo_tune_sched #(.FAST_SIM(0), .DUR_W(DurW)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req),
    .grant_o   (grant),
    .busy_o    (busy),
    .done_o    (done),
    .piezo_o   (piezo),
    .piezo_n_o (piezo_n)
  );

  // Long-duration instance so real tone toggles are observable.
  piezo_tune_sched #(.FAST_SIM(1), .DUR_W(19)) u_fast (
    .clk       (clk),
    .rst_n     (rst_f_n),
    .req_i     (req_f),
    .grant_o   (grant_f),
    .busy_o    (busy_f),
    .done_o    (done_f),
    .piezo_o   (piezo_f),
    .piezo_n_o (piezo_n_f)
  );

  typedef struct {
    bit         is_done;
    logic [2:0] grant;
    int         edge_no;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state.
  int       m_edge    = 0;
  int       m_phase   = 0;  // 0 idle, 1 playing, 2 done cycle
  int       m_owner   = 0;
  int       m_note    = 0;
  int       m_elapsed = 0;
  bit [2:0] m_pend    = '0;

  function automatic int tune_notes(int t);
    return (t == 0) ? 8 : (t == 1) ? 2 : 1;
  endfunction

  // 0 full, 1 long, 2 short
  function automatic int note_code(int t, int n);
    if (t == 1) return 1;
    if (t == 2) return 2;
    case (n)
      3, 5:    return 1;
      4, 6:    return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int note_cycles(int t, int n);
    int full, half;
    full = 1 << DurW;
    half = 1 << (DurW - 1);
    case (note_code(t, n))
      0:       return full;
      1:       return full + half;
      default: return half;
    endcase
  endfunction

  function automatic int lowest(bit [2:0] p);
    for (int i = 0; i < 3; i++) if (p[i]) return i;
    return -1;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, expv, m_edge);
    end
  endtask

  task automatic model_start(int who);
    exp_t e;
    m_pend[who] = 1'b0;
    m_owner     = who;
    m_note      = 0;
    m_elapsed   = 0;
    m_phase     = 1;
    e.is_done   = 1'b0;
    e.grant     = 3'(1 << who);
    e.edge_no   = m_edge;
    exp_q.push_back(e);
  endtask

  // Reference model: tune-level arbitration with note durations from the table.
  initial begin
    bit [2:0] p;
    int       pick;
    exp_t     e;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_phase = 0;
        m_pend  = '0;
        exp_q.delete();
      end else begin
        m_edge++;
        p    = m_pend;
        pick = lowest(p);
        case (m_phase)
          0: if (pick >= 0) model_start(pick);
          1: begin
            m_elapsed++;
            if (m_elapsed == note_cycles(m_owner, m_note)) begin
              m_elapsed = 0;
`ifdef PIEZO_PREEMPT_EN
              if (pick >= 0 && pick < m_owner) model_start(pick);
              else
`endif
              if (m_note == tune_notes(m_owner) - 1) begin
                m_phase   = 2;
                e.is_done = 1'b1;
                e.grant   = 3'b000;
                e.edge_no = m_edge;
                exp_q.push_back(e);
              end else begin
                m_note++;
              end
            end
          end
          default: m_phase = 0;
        endcase
        m_pend = m_pend | req;
      end
    end
  end

  task automatic check_event(bit is_done, logic [2:0] g);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL event: unexpected done=%0b grant=%b at edge %0d", is_done, g, m_edge);
    end else begin
      e = exp_q.pop_front();
      if (e.is_done != is_done || e.grant !== g || e.edge_no != m_edge) begin
        failures++;
        $display("FAIL event: got done=%0b grant=%b edge %0d, expected done=%0b grant=%b edge %0d",
                 is_done, g, m_edge, e.is_done, e.grant, e.edge_no);
      end
    end
  endtask

  // Monitor: event scoreboard plus per-cycle output tracking.
  initial begin
    logic [2:0] prev_g;
    logic [2:0] exp_g;
    exp_t       e;
    prev_g = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_g = '0;
      end else begin
        while (exp_q.size() > 0 && exp_q[0].edge_no < m_edge) begin
          e = exp_q.pop_front();
          checks++;
          failures++;
          $display("FAIL event: missing done=%0b grant=%b due edge %0d", e.is_done, e.grant,
                   e.edge_no);
        end
        if (grant !== prev_g && grant !== 3'b000) check_event(1'b0, grant);
        if (done === 1'b1) check_event(1'b1, 3'b000);
        exp_g = (m_phase == 1) ? 3'(1 << m_owner) : 3'b000;
        chk("grant_track", 32'(grant), 32'(exp_g));
        chk("busy", 32'(busy), 32'(exp_g != 3'b000));
        chk("done_track", 32'(done), 32'(m_phase == 2));
        // Every note here is shorter than one half-period, so piezo never toggles.
        chk("piezo_quiet", 32'(piezo), 32'd0);
        chk("piezo_n", 32'(piezo_n), 32'd1);
        prev_g = grant;
      end
    end
  end

  // Fast instance: fanfare tone toggle timing across the first note boundary.
  initial begin
    int g_edge;
    int tog[$];
    logic last;
    rst_f_n = 1'b1;
    req_f   = '0;
    g_edge  = -1;
    #2 rst_f_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_f_n = 1'b1;
    @(negedge clk);
    req_f = 3'b001;
    @(negedge clk);
    req_f = 3'b000;
    last  = piezo_f;
    for (int i = 0; i < 60000; i++) begin
      @(negedge clk);
      if (g_edge < 0 && grant_f != 3'b000) g_edge = i;
      if (piezo_f !== last) tog.push_back(i);
      last = piezo_f;
      if (piezo_n_f !== ~piezo_f) begin
        chk("fast_piezo_n", 32'(piezo_n_f), 32'(~piezo_f));
      end
      if (g_edge >= 0 && i >= g_edge + 52000) break;
    end
    chk("fast_grant_seen", 32'(g_edge >= 0), 32'd1);
    chk("fast_grant", 32'(grant_f), 32'b001);
    chk("fast_toggle_count", 32'(tog.size()), 32'd2);
    if (tog.size() >= 2 && g_edge >= 0) begin
      chk("fast_toggle1", 32'(tog[0] - g_edge), 32'(HpD7 + 1));
      chk("fast_toggle2", 32'(tog[1] - g_edge), 32'(32768 + HpE7 + 1));
    end
    fast_finished = 1'b1;
  end

  task automatic pulse(logic [2:0] v);
    req = v;
    @(negedge clk);
    req = 3'b000;
  endtask

  task automatic wait_idle(int limit);
    int i;
    i = 0;
    while (!(m_phase == 0 && m_pend == 3'b000) && i < limit) begin
      @(negedge clk);
      i++;
    end
    if (i >= limit) begin
      checks++;
      failures++;
      $display("FAIL wait_idle: still busy after %0d cycles", limit);
    end
  endtask

  task automatic check_reset_values(string tag);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_piezo"}, 32'(piezo), 32'd0);
    chk({tag, "_piezo_n"}, 32'(piezo_n), 32'd1);
  endtask

  // Stimulus.
  initial begin
    int w;
    rst_n = 1'b1;
    req   = 3'b000;
    #2 rst_n = 1'b0;
    #1 check_reset_values("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    pulse(3'b100);
    wait_idle(400);
    pulse(3'b111);
    wait_idle(4000);
    pulse(3'b010);
    repeat (300) @(negedge clk);
    pulse(3'b010);
    wait_idle(2000);

    // Reset in the middle of a fanfare with the chirp pending.
    pulse(3'b001);
    repeat (500) @(negedge clk);
    pulse(3'b100);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("no_regrant", 32'(grant), 32'd0);

    // Fanfare requested while the chirp plays.
    pulse(3'b100);
    repeat (50) @(negedge clk);
    pulse(3'b001);
    wait_idle(3000);

    for (int i = 0; i < 12000; i++) begin
      for (int b = 0; b < 3; b++) req[b] = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    req = 3'b000;
    wait_idle(8000);
    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    w = 0;
    while (!fast_finished && w < 80000) begin
      @(negedge clk);
      w++;
    end
    if (!fast_finished) begin
      checks++;
      failures++;
      $display("FAIL fast_timeout: fast instance check did not complete");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
